// File: rtl/gray_read_arbiter.sv
// Round-robin sharing of the one-cycle-latency gray image read port between two
// requesters; issues are pipelined so two active requesters fill every cycle.
module gray_read_arbiter #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_req,
    input  logic [AW-1:0] req0_addr,
    output logic          req0_ready,
    output logic [DW-1:0] req0_data,
    input  logic          req1_req,
    input  logic [AW-1:0] req1_addr,
    output logic          req1_ready,
    output logic [DW-1:0] req1_data,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_data,
    output logic          busy
);

    logic pend0;
    logic pend1;
    logic last;
    logic elig0;
    logic elig1;
    logic grant_valid;
    logic grant_idx;
    logic issue;

    // A requester with a read in flight is not eligible, which keeps a single
    // active requester at one read per two cycles and lets the other fill the gap.
    always_comb begin
        elig0       = req0_req & ~pend0;
        elig1       = req1_req & ~pend1;
        grant_valid = elig0 | elig1;
        grant_idx   = (elig0 & elig1) ? ~last : elig1;
        issue       = grant_valid & mem_ready;
    end

    assign mem_rd   = grant_valid;
    assign mem_addr = grant_valid ? (grant_idx ? req1_addr : req0_addr) : '0;

    // pend is a one-cycle flag: it covers only the read issued on this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            last  <= 1'b1;
        end else begin
            pend0 <= issue & ~grant_idx;
            pend1 <= issue & grant_idx;
            if (issue) begin
                last <= grant_idx;
            end
        end
    end

    assign req0_ready = pend0;
    assign req1_ready = pend1;
    assign req0_data  = pend0 ? mem_data : '0;
    assign req1_data  = pend1 ? mem_data : '0;
    assign busy       = pend0 | pend1;

endmodule

// File: tb/tb_gray_read_arbiter.sv
// Bench for gray_read_arbiter: scenario tasks check the memory-side timing inline,
// while a scoreboard matches every ready pulse against the pixel expected for it.
module tb_gray_read_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_req = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic          req0_ready;
    logic [DW-1:0] req0_data;
    logic          req1_req = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic          req1_ready;
    logic [DW-1:0] req1_data;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_ready = 1'b1;
    logic [DW-1:0] mem_data = '0;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    gray_read_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_req   (req0_req),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req1_req   (req1_req),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Memory model: data = addr[7:0] + 8'h10 one cycle after an accepted read.
    always @(posedge clk) begin
        if (mem_rd && mem_ready) mem_data <= mem_addr[7:0] + 8'h10;
        else                     mem_data <= 8'hEE;
    end

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return lo + 8'h10;
    endfunction

    // Scoreboard: every ready pops one expected pixel; idle data must be zero.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (req0_ready) begin
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL sb_ready0_unexpected: ready=1, required no read in flight");
                end else begin
                    logic [DW-1:0] e;
                    e = q0.pop_front();
                    if (req0_data !== e) begin
                        errors++;
                        $display("FAIL sb_data0: got %h, required %h", req0_data, e);
                    end
                end
            end else if (req0_data !== '0) begin
                errors++;
                $display("FAIL sb_idle_data0: got %h, required 00", req0_data);
            end
            checks++;
            if (req1_ready) begin
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sb_ready1_unexpected: ready=1, required no read in flight");
                end else begin
                    logic [DW-1:0] e;
                    e = q1.pop_front();
                    if (req1_data !== e) begin
                        errors++;
                        $display("FAIL sb_data1: got %h, required %h", req1_data, e);
                    end
                end
            end else if (req1_data !== '0) begin
                errors++;
                $display("FAIL sb_idle_data1: got %h, required 00", req1_data);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        req0_req = 1'b0;
        req1_req = 1'b0;
        req0_addr = '0;
        req1_addr = '0;
        mem_ready = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: pending q0=%0d q1=%0d, required 0 0", name, q0.size(), q1.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b0 ||
            req0_data !== '0 || req1_data !== '0 || mem_rd !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b%b busy=%b d0=%h d1=%h rd=%b addr=%0d, required all 0",
                     req0_ready, req1_ready, busy, req0_data, req1_data, mem_rd, mem_addr);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req0_req = 1'b1;
            req0_addr = AW'(i);
            #1;
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== AW'(i)) begin
                errors++;
                $display("FAIL single_issue%0d: rd=%b addr=%0d, required 1 %0d", i, mem_rd, mem_addr, i);
            end
            q0.push_back(pix(AW'(i)));
            @(negedge clk);
            #1;
            checks++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL single_ready%0d: rdy0=%b rdy1=%b rd=%b, required 1 0 0",
                         i, req0_ready, req1_ready, mem_rd);
            end
            @(negedge clk);
        end
        req0_req = 1'b0;
        check_drained("single");
    endtask

    task automatic test_both();
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        int g;
        do_reset();
        a0 = AW'(129);
        a1 = AW'(8321);
        req0_req = 1'b1;
        req1_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                checks++;
                if (((c - 1) % 2 == 0 && req0_ready !== 1'b1) || ((c - 1) % 2 == 1 && req1_ready !== 1'b1)) begin
                    errors++;
                    $display("FAIL both_ready_c%0d: rdy0=%b rdy1=%b, required requester %0d",
                             c, req0_ready, req1_ready, (c - 1) % 2);
                end
                if ((c - 1) % 2 == 0) a0 = a0 + 1'b1;
                else                  a1 = a1 + 1'b1;
            end
            req0_addr = a0;
            req1_addr = a1;
            g = c % 2;
            #1;
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== (g == 0 ? a0 : a1)) begin
                errors++;
                $display("FAIL both_grant_c%0d: rd=%b addr=%0d, required 1 %0d",
                         c, mem_rd, mem_addr, (g == 0 ? a0 : a1));
            end
            if (g == 0) q0.push_back(pix(a0));
            else        q1.push_back(pix(a1));
            @(negedge clk);
        end
        req0_req = 1'b0;
        req1_req = 1'b0;
        @(negedge clk);
        check_drained("both");
    endtask

    task automatic test_stall();
        do_reset();
        req1_req = 1'b1;
        req1_addr = AW'(200);
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 3);
            #1;
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== AW'(200) || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_c%0d: rd=%b addr=%0d rdy1=%b, required 1 200 0",
                         c, mem_rd, mem_addr, req1_ready);
            end
            if (c == 3) q1.push_back(pix(AW'(200)));
            @(negedge clk);
        end
        req1_req = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready: rdy1=%b, required 1", req1_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req1_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_pulse: rdy1=%b busy=%b, required 0 0", req1_ready, busy);
        end
        check_drained("stall");
    endtask

    task automatic test_withdraw();
        do_reset();
        req0_req = 1'b1;
        req0_addr = AW'(5);
        #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== AW'(5)) begin
            errors++;
            $display("FAIL withdraw_issue: rd=%b addr=%0d, required 1 5", mem_rd, mem_addr);
        end
        q0.push_back(pix(AW'(5)));
        @(negedge clk);
        req0_req = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_ready: rdy0=%b rd=%b, required 1 0", req0_ready, mem_rd);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (req0_ready !== 1'b0 || mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL withdraw_quiet_c%0d: rdy0=%b rd=%b, required 0 0", c, req0_ready, mem_rd);
            end
        end
        check_drained("withdraw");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        // Skew arbitration so last points at requester 1 before the lost read.
        req1_req = 1'b1;
        req1_addr = AW'(77);
        #1;
        q1.push_back(pix(AW'(77)));
        @(negedge clk);
        req1_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b0 || busy !== 1'b0 || req1_data !== '0) begin
            errors++;
            $display("FAIL midflight_drop: rdy1=%b busy=%b d1=%h, required 0 0 00", req1_ready, busy, req1_data);
        end
        q1.delete();
        req0_req = 1'b1;
        req1_req = 1'b1;
        req0_addr = AW'(10);
        req1_addr = AW'(20);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== AW'(10)) begin
            errors++;
            $display("FAIL midflight_first_grant: rd=%b addr=%0d, required 1 10", mem_rd, mem_addr);
        end
        q0.push_back(pix(AW'(10)));
        @(negedge clk);
        req0_req = 1'b0;
        #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== AW'(20)) begin
            errors++;
            $display("FAIL midflight_second_grant: rd=%b addr=%0d, required 1 20", mem_rd, mem_addr);
        end
        q1.push_back(pix(AW'(20)));
        @(negedge clk);
        req1_req = 1'b0;
        @(negedge clk);
        check_drained("midflight");
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time=%0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_both();
        test_stall();
        test_withdraw();
        test_reset_midflight();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_read_arbiter.md
# gray_read_arbiter

Shares the single read port of the gray image memory between two LBP-style requesters, each using the gray_req/gray_addr/gray_ready/gray_data handshake. It sits between the requesters (for example, two LBP engines each working on half the image) and the image memory. The memory has a one-cycle read latency. Arbitration is round-robin per access, and issues are pipelined, so two active requesters can keep the memory port busy every cycle.

## Interface
- AW, 14, address width (128x128 image)
- DW, 8, pixel width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0_req  in  1  requester 0 wants the pixel at req0_addr
- req0_addr  in  AW  requester 0 address; held stable until req0_ready
- req0_ready  out  1  req0_data is valid for the address held by requester 0
- req0_data  out  DW  pixel for requester 0
- req1_req, req1_addr, req1_ready, req1_data: same as requester 0, for requester 1
- mem_rd  out  1  read strobe to memory
- mem_addr  out  AW  read address
- mem_ready  in  1  memory accepts mem_rd this cycle; when low, the strobe is not taken
- mem_data  in  DW  read data, valid the cycle after an accepted read
- busy  out  1  a read is in flight (pend0 or pend1 set)

## Operation
- State:
  - pend0, pend1: requester has a read in flight.
  - last: index of the last granted requester.
  - Reset values: pend0 = pend1 = 0, last = 1, so requester 0 wins the first tie.
- Eligibility: eligN = reqN_req & ~pendN.
- Grant (combinational):
  - Only elig0: grant 0.
  - Only elig1: grant 1.
  - Both: grant ~last.
  - Neither: no grant.
- Memory drive (combinational):
  - mem_rd = any grant.
  - mem_addr = address of the granted requester; 0 when no grant.
- Accepted issue: a grant with mem_ready = 1. On the clock edge:
  - the granted pendN is set;
  - last is set to the granted index;
  - every pend not set by this issue is cleared (pend is a one-cycle flag).
- Unaccepted grant (mem_ready = 0): no state change. The same arbitration is evaluated again next cycle, and the requester's address must still be held.
- Outputs:
  - reqN_ready = pendN.
  - reqN_data = mem_data when pendN = 1, else 0.
- Only one pend bit can be set at a time, because at most one issue is accepted per cycle.
- Dropping reqN_req while pendN = 1 does not cancel the read. reqN_ready still pulses and the data is discarded by the requester.
- The arbiter does not modify or check addresses. Range checks on req addresses are the requester's job.

## Timing
- Reset values of outputs:
  - req0_ready = req1_ready = 0, req0_data = req1_data = 0, busy = 0.
  - mem_rd and mem_addr = 0 unless a request is present, because they are combinational from the request inputs.
- Latency: request seen in cycle t with mem_ready = 1 → mem_rd in cycle t → ready and data in cycle t+1.
- A requester that updates its address on ready sees its next request eligible at t+2.
  - Single active requester: one read every 2 cycles.
  - Two active requesters: one read every cycle, alternating 0,1,0,1.
- Fairness: while both requesters are eligible, grants strictly alternate. A requester that is eligible waits at most one accepted issue.
- Memory stall: each cycle with mem_ready = 0 adds exactly one cycle of latency. Pend bits clear normally during a stall.
- Asynchronous reset during an in-flight read:
  - pend bits clear immediately, so ready drops in the same cycle;
  - no ready is produced for the lost read;
  - the first grant after reset is requester 0.
- No combinational path from reqN_ready back into mem_rd within a cycle. pend is registered.

## Test plan
- Single requester:
  - Stimulus: req0 reads addresses 0, 1, 2; memory returns data = addr[7:0] + 8'h10.
  - Required: mem_rd high in cycles 0, 2, 4.
  - Required: req0_ready high in cycles 1, 3, 5 with data 8'h10, 8'h11, 8'h12; req1_ready stays 0.
- Both requesting, mem_ready = 1:
  - Stimulus: req0 at addr 129, req1 at addr 8321, each advancing its address on ready.
  - Required: grants alternate 0,1,0,1 starting with 0.
  - Required: mem_rd high in every cycle; each requester gets one pixel per 2 cycles.
- Memory stall:
  - Stimulus: req1 alone at addr 200; mem_ready = 0 for 3 cycles, then 1.
  - Required: mem_addr = 200 held for 4 cycles; req1_ready pulses exactly once, in the cycle after mem_ready goes high.
- Request withdrawn:
  - Stimulus: req0 issued at addr 5; req0_req drops the next cycle.
  - Required: req0_ready still pulses once; no further mem_rd is issued.
- Reset mid-flight:
  - Stimulus: assert reset in the cycle after an accepted issue for requester 1.
  - Required: req1_ready = 0 immediately.
  - Required: after release with both requesting, requester 0 wins the first grant.
